mem_slave: RTL and testbench
============================

# mem_slave

Byte-organised memory responder for the memory bus: accepts 32-bit word writes and 8-bit byte reads on a shared 8-bit byte address. It is the design-under-test end of the bus whose driver and monitor live in the memory testbench interface. Registered read data, wrap-around multi-byte writes, and a post-reset clearing sequence give the verification environment deterministic contents and latency.

## Interface
- DEPTH, 256, number of bytes; must equal 2**ADDR_W
- ADDR_W, 8, byte address width
- WDATA_W, 32, write data width; must be a multiple of RDATA_W
- RDATA_W, 8, read data width (one byte)
- clk  input  1  single clock; all logic on posedge
- rstn  input  1  reset, synchronous, active-low
- wr_en  input  1  write request, sampled on posedge
- w_data  input  WDATA_W  write data; byte k = w_data[8k+7:8k]
- addr  input  ADDR_W  byte address for both reads and writes
- rd_en  input  1  read request, sampled on posedge
- r_data  output  RDATA_W  registered read data
- rd_valid  output  1  one-cycle pulse marking r_data updated by a read
- busy  output  1  high while the clearing sequence runs; requests ignored

## Operation
- Storage: DEPTH x 8-bit array; LANES = WDATA_W/RDATA_W (4).
- States: INIT (clearing), IDLE (serving). No other states.
- INIT: clear pointer clr_ptr starts at 0; each posedge writes 0 to mem[clr_ptr], then increments clr_ptr. After the edge that clears mem[DEPTH-1], state -> IDLE. wr_en/rd_en ignored in INIT; no write, no read response.
- IDLE write: wr_en=1 -> mem[(addr+k) mod DEPTH] <= byte k, for k = 0..LANES-1. Address wraps: addr=0xFE writes bytes 0,1 to 0xFE,0xFF and bytes 2,3 to 0x00,0x01.
- IDLE read: rd_en=1 -> r_data <= mem[addr], rd_valid <= 1. Without rd_en, rd_valid <= 0 and r_data holds its last value.
- wr_en and rd_en together: both serviced. The read returns contents from before that cycle's write (read-before-write), including when addr overlaps the written bytes.
- Read after write: a read sampled on the edge after a write returns the newly written data.
- Address arithmetic is ADDR_W bits, modulo DEPTH; no out-of-range case exists.

## Timing
- Reset (rstn=0 at a posedge): r_data=0, rd_valid=0, busy=1, state=INIT, clr_ptr=0. Array contents are not reset directly; INIT clears them.
- Reset mid-operation (IDLE or INIT): the same values apply on that edge, and INIT restarts from clr_ptr=0.
- Clear duration: let E0 be the first posedge with rstn=1. E0 clears byte 0 and E255 clears byte 255. busy falls after E255. The first request accepted is sampled at E256.
- Write latency: data is stored at the sampling edge and is visible to a read sampled on the next edge.
- Read latency: request sampled at edge N; r_data and rd_valid change just after edge N and are sampled by the bench at edge N+1 (input skew #1). rd_valid stays high for exactly one cycle per rd_en; back-to-back reads give a continuous rd_valid.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset/clear: hold rstn=0 for 3 cycles, release. Required: busy=1 for exactly 256 cycles; then reading all 256 addresses returns 0x00 with rd_valid pulsing on each read.
- Basic write/read: write w_data=0xDDCCBBAA at addr=0x10, then read 0x10..0x13. Required: r_data = 0xAA, 0xBB, 0xCC, 0xDD at 1-cycle latency.
- Wrap-around: write 0x44332211 at addr=0xFE, then read 0xFE, 0xFF, 0x00, 0x01. Required: 0x11, 0x22, 0x33, 0x44.
- Simultaneous access: with mem[0x20]=0x5A, assert wr_en (w_data=0x000000A5, addr=0x20) and rd_en in the same cycle. Required: r_data=0x5A. A read on the next cycle returns 0xA5.
- Ignored in INIT: assert wr_en/rd_en with addr=0x00, w_data=0xFFFFFFFF during clearing. Required: rd_valid stays 0, r_data stays 0, and mem[0x00] reads 0x00 after busy falls.
- Reset mid-operation: during back-to-back reads, pull rstn low for 1 cycle. Required: rd_valid=0 and r_data=0 on that edge, busy=1 for 256 cycles, and previously written data reads back as 0x00.

Source files
------------

// File: rtl/mem_slave_if.sv
// mem_slave_if: memory bus between the memory test environment (master)
// and the byte-organised memory responder (slave).
//   wr_en, w_data : word write request and data (byte k = w_data[8k+7:8k])
//   addr          : shared byte address for reads and writes
//   rd_en         : byte read request
//   r_data        : registered read byte
//   rd_valid      : one-cycle pulse marking r_data updated by a read
//   busy          : high while the responder clears its storage
interface mem_slave_if #(
   parameter int ADDR_W  = 8,
   parameter int WDATA_W = 32,
   parameter int RDATA_W = 8
);
   logic               wr_en;
   logic [WDATA_W-1:0] w_data;
   logic [ADDR_W-1:0]  addr;
   logic               rd_en;
   logic [RDATA_W-1:0] r_data;
   logic               rd_valid;
   logic               busy;

   modport master (
      output wr_en, w_data, addr, rd_en,
      input  r_data, rd_valid, busy
   );

   modport slave (
      input  wr_en, w_data, addr, rd_en,
      output r_data, rd_valid, busy
   );
endinterface

// File: rtl/mem_slave.sv
// mem_slave: byte-organised memory responder.
// Accepts word writes (LANES bytes stored at addr..addr+LANES-1, wrapping
// modulo DEPTH) and single-byte reads with registered data. After reset the
// whole array is cleared one byte per clock (busy high); requests are ignored
// until clearing completes.
// Ports:
//   clk  : single clock, all logic on posedge
//   rstn : synchronous active-low reset
//   bus  : mem_slave_if slave modport (wr_en, w_data, addr, rd_en in;
//          r_data, rd_valid, busy out, all registered)
module mem_slave #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int WDATA_W = 32,
   parameter int RDATA_W = 8
) (
   input logic        clk,
   input logic        rstn,
   mem_slave_if.slave bus
);

   localparam int LANES = WDATA_W / RDATA_W;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   clr_ptr_r;
   logic [RDATA_W-1:0]  r_data_r;
   logic                rd_valid_r;
   logic                busy_r;
   logic [RDATA_W-1:0]  mem_r [DEPTH];
   logic [ADDR_W-1:0]   lane_addr_s [LANES];

   // Per-lane byte address; ADDR_W-bit arithmetic gives the modulo-DEPTH wrap.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         lane_addr_s[k] = bus.addr + ADDR_W'(k);
      end
   end

   // Control FSM: clearing sequence, read response and busy flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r    <= ST_INIT;
         clr_ptr_r  <= {ADDR_W{1'b0}};
         r_data_r   <= {RDATA_W{1'b0}};
         rd_valid_r <= 1'b0;
         busy_r     <= 1'b1;
      end else begin
         case (state_r)
            ST_INIT: begin
               rd_valid_r <= 1'b0;
               clr_ptr_r  <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               if (clr_ptr_r == ADDR_W'(DEPTH - 1)) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_INIT;
                  busy_r  <= 1'b1;
               end
            end
            ST_IDLE: begin
               busy_r <= 1'b0;
               if (bus.rd_en) begin
                  // Non-blocking read of mem_r returns pre-write contents
                  // when a write to the same byte happens on this edge.
                  r_data_r   <= mem_r[bus.addr];
                  rd_valid_r <= 1'b1;
               end else begin
                  rd_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_INIT;
               clr_ptr_r  <= {ADDR_W{1'b0}};
               rd_valid_r <= 1'b0;
               busy_r     <= 1'b1;
            end
         endcase
      end
   end

   // Storage: zero-fill during clearing, lane-wise word writes when serving.
   always_ff @(posedge clk) begin
      if (rstn && (state_r == ST_INIT)) begin
         mem_r[clr_ptr_r] <= {RDATA_W{1'b0}};
      end else if (rstn && (state_r == ST_IDLE) && bus.wr_en) begin
         for (int k = 0; k < LANES; k++) begin
            mem_r[lane_addr_s[k]] <= bus.w_data[k*RDATA_W +: RDATA_W];
         end
      end
   end

   assign bus.r_data   = r_data_r;
   assign bus.rd_valid = rd_valid_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_mem_slave.sv
// tb_mem_slave: directed self-checking bench for mem_slave.
// Inputs are driven and outputs sampled 1 time unit after each posedge.
module tb_mem_slave;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_err;

   mem_slave_if #(.ADDR_W(8), .WDATA_W(32), .RDATA_W(8)) bus ();

   mem_slave #(
      .DEPTH  (256),
      .ADDR_W (8),
      .WDATA_W(32),
      .RDATA_W(8)
   ) u_dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Read one byte: request sampled at next edge, checked right after it.
   task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
      bus.rd_en = 1'b1;
      bus.addr  = a;
      tick();
      chk({tag, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
      chk(tag, {24'd0, bus.r_data}, {24'd0, exp});
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus.rd_en  = 1'b0;
      bus.wr_en  = 1'b1;
      bus.addr   = a;
      bus.w_data = d;
      tick();
      bus.wr_en  = 1'b0;
   endtask

   // Count edges until busy falls; optionally verify no read response meanwhile.
   task automatic wait_clear(input string tag, input bit chk_quiet);
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 400) begin
         tick();
         n++;
         if (chk_quiet) begin
            chk({tag, "_rdv_init"}, {31'd0, bus.rd_valid}, 32'd0);
            chk({tag, "_rdata_init"}, {24'd0, bus.r_data}, 32'd0);
         end
      end
      chk({tag, "_busy_cycles"}, n, 32'd256);
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rstn        = 1'b0;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.addr    = 8'h00;
      bus.w_data  = 32'h0;

      // Reset held for 3 cycles.
      tick(); tick(); tick();
      chk("rst_busy", {31'd0, bus.busy}, 32'd1);
      chk("rst_rdv", {31'd0, bus.rd_valid}, 32'd0);
      chk("rst_rdata", {24'd0, bus.r_data}, 32'd0);

      // Release reset with requests asserted during clearing; all ignored.
      rstn       = 1'b1;
      bus.wr_en  = 1'b1;
      bus.rd_en  = 1'b1;
      bus.addr   = 8'h00;
      bus.w_data = 32'hFFFF_FFFF;
      wait_clear("clr1", 1'b1);
      bus.wr_en  = 1'b0;
      bus.rd_en  = 1'b0;

      // Whole array reads zero, back-to-back with continuous rd_valid.
      for (int a = 0; a < 256; a++) begin
         rd("clr_read", 8'(a), 8'h00);
      end
      bus.rd_en = 1'b0;
      tick();
      chk("idle_rdv", {31'd0, bus.rd_valid}, 32'd0);

      // Basic write / read.
      wr(8'h10, 32'hDDCC_BBAA);
      rd("basic0", 8'h10, 8'hAA);
      rd("basic1", 8'h11, 8'hBB);
      rd("basic2", 8'h12, 8'hCC);
      rd("basic3", 8'h13, 8'hDD);
      bus.rd_en = 1'b0;
      tick();
      chk("hold_rdv", {31'd0, bus.rd_valid}, 32'd0);
      chk("hold_rdata", {24'd0, bus.r_data}, 32'h0000_00DD);

      // Wrap-around write.
      wr(8'hFE, 32'h4433_2211);
      rd("wrap_fe", 8'hFE, 8'h11);
      rd("wrap_ff", 8'hFF, 8'h22);
      rd("wrap_00", 8'h00, 8'h33);
      rd("wrap_01", 8'h01, 8'h44);
      rd("wrap_02", 8'h02, 8'h00);
      rd("wrap_fd", 8'hFD, 8'h00);

      // Simultaneous write and read: read sees old contents.
      wr(8'h20, 32'h0000_005A);
      bus.wr_en  = 1'b1;
      bus.w_data = 32'h0000_00A5;
      rd("simul_old", 8'h20, 8'h5A);
      bus.wr_en  = 1'b0;
      rd("simul_new", 8'h20, 8'hA5);
      rd("simul_21", 8'h21, 8'h00);

      // Reset in the middle of back-to-back reads.
      rd("mid_rd0", 8'h10, 8'hAA);
      rd("mid_rd1", 8'h11, 8'hBB);
      rstn = 1'b0;
      bus.addr = 8'h12;
      tick();
      chk("mid_rst_rdv", {31'd0, bus.rd_valid}, 32'd0);
      chk("mid_rst_rdata", {24'd0, bus.r_data}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd1);
      rstn      = 1'b1;
      bus.rd_en = 1'b0;
      wait_clear("clr2", 1'b0);
      rd("post_10", 8'h10, 8'h00);
      rd("post_13", 8'h13, 8'h00);
      rd("post_fe", 8'hFE, 8'h00);
      rd("post_20", 8'h20, 8'h00);
      bus.rd_en = 1'b0;
      tick();
      chk("end_rdv", {31'd0, bus.rd_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
